rf_port_arbiter: RTL and testbench

- Shares the register file's single read port and single write port between NUM_REQ requesters (decode operand fetch, writeback, debug).
- Round-robin arbitration with a valid/ready handshake; at most one register-file operation (read or write) per cycle.
- Supports an optional lock so one requester can run an atomic read-modify-write sequence.
- Sits between the pipeline stages and the main register file inside the core.

---
 rtl/rf_port_arbiter_pkg.sv | 18 +
 rtl/rf_port_arbiter_if.sv | 28 ++
 rtl/rf_port_arbiter_rr_picker.sv | 11 +
 rtl/rf_port_arbiter.sv | 73 +++++++
 tb/tb_rf_port_arbiter.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/rf_port_arbiter_pkg.sv
// rf_arb_pkg: shared state type, default widths and the round-robin pick helper
// used by the register-file port arbiter.
package rf_arb_pkg;
  typedef enum logic {ARB_IDLE_ARB, ARB_LOCKED} rf_arb_state_e;
  localparam int RF_ADDR_W = 6;
  localparam int RF_DATA_W = 32;
  localparam int RF_MAX_REQ = 8;
  // Scans from ptr upward, wrapping at n; the last match assigned is the closest to ptr.
  function automatic logic [RF_MAX_REQ-1:0] rr_pick(input logic [RF_MAX_REQ-1:0] valid,
                                                    input logic [2:0] ptr, input int n);
    logic [2:0] idx;
    rr_pick = '0;
    for (int k = n - 1; k >= 0; k--) begin
      idx = 3'((int'(ptr) + k) % n);
      if (valid[idx]) rr_pick = RF_MAX_REQ'(1) << idx;
    end
  endfunction
endpackage

// File: rtl/rf_port_arbiter_if.sv
// rf_port_arbiter_if: requester-side handshake plus register-file port signals.
interface rf_port_arbiter_if import rf_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_we;
  logic [NUM_REQ-1:0] req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rf_rd_reg_num;
  logic [DATA_W-1:0] rf_read_data;
  logic [ADDR_W-1:0] rf_wr_reg_num;
  logic rf_write_en;
  logic [DATA_W-1:0] rf_write_data;
  modport slave (
    input req_valid, req_we, req_lock, req_addr, req_wdata, rf_read_data,
    output req_ready, rsp_valid, rsp_data, rf_rd_reg_num, rf_wr_reg_num, rf_write_en, rf_write_data
  );
  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, rf_read_data,
    input req_ready, rsp_valid, rsp_data, rf_rd_reg_num, rf_wr_reg_num, rf_write_en, rf_write_data
  );
endinterface

// File: rtl/rf_port_arbiter_rr_picker.sv
// rf_rr_picker: combinational one-hot round-robin selector starting at ptr_i.
module rf_rr_picker import rf_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);
  assign grant_o = NUM_REQ'(rr_pick(RF_MAX_REQ'(valid_i), 3'(ptr_i), NUM_REQ));
endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: round-robin sharing of the register file read/write ports with lock.
// Define RF_ARB_WR_PRIO_EN to let any valid write beat all reads while arbitrating.
module rf_port_arbiter import rf_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input logic clk,
  input logic rst,
  rf_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  rf_arb_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, gnt_idx;
  logic [NUM_REQ-1:0] pick_valid, pick_grant, ready, rd_gnt, rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d, sel_wdata;
  logic [ADDR_W-1:0] sel_addr;
  logic gnt, gnt_we, gnt_lock;
`ifdef RF_ARB_WR_PRIO_EN
  logic [NUM_REQ-1:0] wr_valid;
  assign wr_valid = bus.req_valid & bus.req_we;
  assign pick_valid = |wr_valid ? wr_valid : bus.req_valid;
`else
  assign pick_valid = bus.req_valid;
`endif
  rf_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid_i(pick_valid),
    .ptr_i(ptr_q),
    .grant_o(pick_grant)
  );
  always_comb begin
    ready = rst ? '0 : state_q == ARB_LOCKED ? bus.req_valid & (NUM_REQ'(1) << owner_q) : pick_grant;
    gnt_idx = '0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (ready[i]) begin
        gnt_idx = PW'(i);
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    gnt = |ready;
    gnt_we = |(ready & bus.req_we);
    gnt_lock = |(ready & bus.req_lock);
    rd_gnt = ready & ~bus.req_we;
    ptr_d = gnt ? (gnt_idx == PW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    state_d = gnt ? (gnt_lock ? ARB_LOCKED : ARB_IDLE_ARB) : state_q;
    owner_d = gnt ? gnt_idx : owner_q;
    rsp_data_d = |rd_gnt ? bus.rf_read_data : rsp_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE_ARB;
      ptr_q <= '0;
      owner_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      rsp_valid_q <= rd_gnt;
      rsp_data_q <= rsp_data_d;
    end
  end
  assign bus.req_ready = ready;
  assign bus.rf_write_en = gnt_we;
  assign bus.rf_wr_reg_num = gnt_we ? sel_addr : '0;
  assign bus.rf_write_data = gnt_we ? sel_wdata : '0;
  assign bus.rf_rd_reg_num = |rd_gnt ? sel_addr : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data = rsp_data_q;
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed and random requests checked against a behavioural arbiter model.
module tb_rf_port_arbiter;
  localparam int N = 3;
  localparam int AW = 6;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  rf_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();
  rf_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [DW-1:0] pat(input int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h9E3779B1);
  endfunction
  logic [DW-1:0] rf_mem [64];
  logic [DW-1:0] ref_mem [64];
  always @(posedge clk)
    if (rst) for (int i = 0; i < 64; i++) rf_mem[i] <= pat(i);
    else if (bus.rf_write_en) rf_mem[bus.rf_wr_reg_num] <= bus.rf_write_data;
  assign bus.rf_read_data = rf_mem[bus.rf_rd_reg_num];
  bit cur_v [N];
  bit cur_we [N];
  bit cur_lk [N];
  logic [AW-1:0] cur_addr [N];
  logic [DW-1:0] cur_wd [N];
  int ptr, owner, pidx, g;
  bit locked, pend;
  logic [DW-1:0] held;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    cur_v[i] = v; cur_we[i] = we; cur_lk[i] = lk; cur_addr[i] = a; cur_wd[i] = d;
  endtask
  task automatic regen(input int i, input int pv);
    set_req(i, $urandom_range(99) < pv, 1'($urandom_range(1)), $urandom_range(99) < 15,
            AW'($urandom_range(63)), $urandom);
  endtask
  // One cycle: drive held requests, check outputs against the model, clock, advance the model.
  task automatic step(output int gout);
    logic [N-1:0] vv, ww, cand;
    bit gw;
    vv = '0; ww = '0; gw = 1'b0; gout = -1;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = cur_v[i];
      bus.req_we[i] = cur_we[i];
      bus.req_lock[i] = cur_lk[i];
      bus.req_addr[i*AW +: AW] = cur_addr[i];
      bus.req_wdata[i*DW +: DW] = cur_wd[i];
      vv[i] = cur_v[i];
      ww[i] = cur_v[i] && cur_we[i];
    end
    #2;
    if (rst) begin
      ptr = 0; owner = 0; locked = 0; pend = 0; held = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    end else if (locked) gout = vv[owner] ? owner : -1;
    else begin
      cand = vv;
`ifdef RF_ARB_WR_PRIO_EN
      if (ww != 0) cand = ww;
`endif
      for (int k = 0; k < N; k++)
        if (gout < 0 && cand[(ptr + k) % N]) gout = (ptr + k) % N;
    end
    if (gout >= 0) gw = cur_we[gout];
    chk("req_ready", 64'(bus.req_ready), gout >= 0 ? 64'd1 << gout : 64'd0);
    chk("rf_write_en", 64'(bus.rf_write_en), 64'(gout >= 0 && gw));
    chk("rf_wr_reg_num", 64'(bus.rf_wr_reg_num), gout >= 0 && gw ? 64'(cur_addr[gout]) : 64'd0);
    chk("rf_write_data", 64'(bus.rf_write_data), gout >= 0 && gw ? 64'(cur_wd[gout]) : 64'd0);
    chk("rf_rd_reg_num", 64'(bus.rf_rd_reg_num), gout >= 0 && !gw ? 64'(cur_addr[gout]) : 64'd0);
    chk("rsp_valid", 64'(bus.rsp_valid), pend ? 64'd1 << pidx : 64'd0);
    chk("rsp_data", 64'(bus.rsp_data), 64'(held));
    @(posedge clk);
    #1;
    pend = 0;
    if (gout >= 0) begin
      if (gw) ref_mem[cur_addr[gout]] = cur_wd[gout];
      else begin pend = 1; pidx = gout; held = ref_mem[cur_addr[gout]]; end
      ptr = (gout + 1) % N;
      locked = cur_lk[gout];
      owner = gout;
    end
  endtask
  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, AW'(i + 1), '0);
    step(g);
    step(g);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) step(g);
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, '0, '0);
    set_req(1, 1, 1, 0, 6'd5, 32'hDEADBEEF);
    step(g);
    set_req(1, 0, 0, 0, '0, '0);
    set_req(0, 1, 0, 0, 6'd5, '0);
    step(g);
    chk("wr_then_rd_data", 64'(bus.rsp_data), 64'h0000_0000_DEAD_BEEF);
    set_req(0, 0, 0, 0, '0, '0);
    set_req(2, 1, 0, 1, 6'd4, '0);
    step(g);
    set_req(0, 1, 0, 0, 6'd7, '0);
    set_req(1, 1, 0, 0, 6'd8, '0);
    set_req(2, 0, 0, 0, '0, '0);
    step(g);
    step(g);
    set_req(2, 1, 1, 0, 6'd4, 32'h1234_5678);
    step(g);
    set_req(2, 0, 0, 0, '0, '0);
    step(g);
    step(g);
    set_req(2, 1, 0, 1, 6'd9, '0);
    step(g);
    step(g);
    rst = 1'b1;
    step(g);
    step(g);
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, AW'(i + 10), '0);
    step(g);
    step(g);
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, '0, '0);
    step(g);
    step(g);
    set_req(0, 1, 0, 0, 6'd3, '0);
    set_req(2, 1, 1, 0, 6'd6, 32'hCAFE_F00D);
    step(g);
    step(g);
    step(g);
    for (int c = 0; c < 400; c++) begin
      step(g);
      if (g >= 0) regen(g, 70);
      for (int i = 0; i < N; i++)
        if (!cur_v[i] && i != g && $urandom_range(99) < 30) regen(i, 100);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
